// File: rtl/timer_cmp_pkg.sv
// ----------------------------------------------------------------------------
// timer_cmp_pkg : shared types and default widths for the compare timer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package timer_cmp_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 32;
  localparam int unsigned OVR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_ONESHOT    = 1'b0,
    MODE_CONTINUOUS = 1'b1
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/timer_cmp_irq.sv
// ----------------------------------------------------------------------------
// timer_cmp_irq : level interrupt with ack and optional saturating overrun count
// Optional: TIMER_CMP_OVERRUN_EN adds overrun_o. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module timer_cmp_irq
  import timer_cmp_pkg::*;
#(
  parameter int unsigned OVR_WIDTH = OVR_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 set_i,
  input  logic                 ack_i,
  output logic                 irq_o
`ifdef TIMER_CMP_OVERRUN_EN
  ,
  output logic [OVR_WIDTH-1:0] overrun_o
`endif
);

  logic r_irq;

  // A set in the same cycle as an ack wins, so a fresh event is never lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq <= 1'b0;
    end else if (set_i) begin
      r_irq <= 1'b1;
    end else if (ack_i) begin
      r_irq <= 1'b0;
    end
  end

  assign irq_o = r_irq;

`ifdef TIMER_CMP_OVERRUN_EN
  localparam logic [OVR_WIDTH-1:0] c_ovr_one = OVR_WIDTH'(1);

  logic [OVR_WIDTH-1:0] r_ovr;
  logic                 w_inc;

  assign w_inc = set_i & r_irq;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovr <= '0;
    end else if (w_inc) begin
      if (ack_i) begin
        r_ovr <= c_ovr_one;
      end else if (r_ovr != '1) begin
        r_ovr <= r_ovr + c_ovr_one;
      end
    end else if (ack_i) begin
      r_ovr <= '0;
    end
  end

  assign overrun_o = r_ovr;
`else
  if (OVR_WIDTH == 0) begin : g_no_overrun
  end
`endif

endmodule

`default_nettype wire

// File: rtl/timer_cmp_unit.sv
// ----------------------------------------------------------------------------
// timer_cmp_unit : compare/match timer FSM driving an external counter
// Optional: TIMER_CMP_OVERRUN_EN adds overrun_o. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module timer_cmp_unit
  import timer_cmp_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned OVR_WIDTH = OVR_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 mode_i,
  input  logic                 cmp_we_i,
  input  logic [CNT_WIDTH-1:0] cmp_value_i,
  input  logic [CNT_WIDTH-1:0] counter_value_i,
  output logic                 counter_enable_o,
  output logic                 counter_clear_o,
  output logic                 event_o,
  output logic                 irq_o,
  input  logic                 irq_ack_i,
  output logic [1:0]           state_o
`ifdef TIMER_CMP_OVERRUN_EN
  ,
  output logic [OVR_WIDTH-1:0] overrun_o
`endif
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ARMED = ST_ARMED;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]           r_state;
  logic [1:0]           w_state;
  logic [1:0]           w_state_nxt;
  mode_e                r_mode;
  logic                 r_cnt_en;
  logic                 r_event;
  logic [CNT_WIDTH-1:0] r_cmp_shadow;
  logic [CNT_WIDTH-1:0] r_cmp_active;
  logic [CNT_WIDTH-1:0] w_shadow_nxt;
  logic                 w_armed;
  logic                 w_start;
  logic                 w_match;

  // Encoding 3 is folded into IDLE so a corrupted state register self-recovers.
  assign w_state      = (r_state == S_ARMED || r_state == S_DONE) ? r_state : S_IDLE;
  assign w_armed      = (w_state == S_ARMED);
  assign w_start      = start_i & ~stop_i;
  assign w_match      = w_armed & r_cnt_en & (counter_value_i == r_cmp_active);
  assign w_shadow_nxt = cmp_we_i ? cmp_value_i : r_cmp_shadow;

  always_comb begin
    w_state_nxt = w_state;
    if (stop_i) begin
      w_state_nxt = S_IDLE;
    end else if (start_i) begin
      w_state_nxt = S_ARMED;
    end else if (w_match && r_mode == MODE_ONESHOT) begin
      w_state_nxt = S_DONE;
    end
  end

  // The forwarded shadow lets a write landing on a match apply to the next period.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_mode       <= MODE_ONESHOT;
      r_cnt_en     <= 1'b0;
      r_event      <= 1'b0;
      r_cmp_shadow <= '0;
      r_cmp_active <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt_en     <= (w_state_nxt == S_ARMED);
      r_event      <= w_match;
      r_cmp_shadow <= w_shadow_nxt;
      if (!w_armed || w_match || w_start) begin
        r_cmp_active <= w_shadow_nxt;
      end
      if (w_start) begin
        r_mode <= mode_e'(mode_i);
      end
    end
  end

  assign counter_enable_o = r_cnt_en;
  assign counter_clear_o  = w_start | (w_match & (r_mode == MODE_CONTINUOUS));
  assign event_o          = r_event;
  assign state_o          = w_state;

  timer_cmp_irq #(
    .OVR_WIDTH (OVR_WIDTH)
  ) u_irq (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .set_i     (w_match),
    .ack_i     (irq_ack_i),
    .irq_o     (irq_o)
`ifdef TIMER_CMP_OVERRUN_EN
    ,
    .overrun_o (overrun_o)
`endif
  );

endmodule

`default_nettype wire

// File: tb/tb_timer_cmp_unit.sv
// ----------------------------------------------------------------------------
// tb_timer_cmp_unit : directed scoreboard bench for timer_cmp_unit
// Optional: TIMER_CMP_OVERRUN_EN enables overrun_o checks. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_timer_cmp_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic        cmp_we = 1'b0;
  logic [31:0] cmp_value = '0;
  logic [31:0] cnt = '0;
  logic        irq_ack = 1'b0;
  logic        counter_enable_o;
  logic        counter_clear_o;
  logic        event_o;
  logic        irq_o;
  logic [1:0]  state_o;
`ifdef TIMER_CMP_OVERRUN_EN
  logic [7:0]  overrun_o;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int s;
  int e_last;

  timer_cmp_unit dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start),
    .stop_i           (stop),
    .mode_i           (mode),
    .cmp_we_i         (cmp_we),
    .cmp_value_i      (cmp_value),
    .counter_value_i  (cnt),
    .counter_enable_o (counter_enable_o),
    .counter_clear_o  (counter_clear_o),
    .event_o          (event_o),
    .irq_o            (irq_o),
    .irq_ack_i        (irq_ack),
    .state_o          (state_o)
`ifdef TIMER_CMP_OVERRUN_EN
    ,
    .overrun_o        (overrun_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream counter with init value 0.
  always @(posedge clk) begin
    if (counter_clear_o) cnt <= '0;
    else if (counter_enable_o) cnt <= cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && event_o) begin
      if (exp_q.size() == 0) check_eq("evt_unexpected", {31'd0, event_o}, 32'd0);
      else check_eq("evt_cycle", cyc, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drain(input string tag);
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic ack_irq();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check_eq("irq_ack_clear", {31'd0, irq_o}, 32'd0);
  endtask

  task automatic arm(input logic [31:0] val, input logic m);
    tick();
    s = cyc;
    cmp_we = 1'b1; cmp_value = val; start = 1'b1; mode = m;
    #1 check_eq("clear_at_start", {31'd0, counter_clear_o}, 32'd1);
    tick();
    cmp_we = 1'b0; start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check_eq("rst_state", state_o, 0);
    check_eq("rst_en", {31'd0, counter_enable_o}, 0);
    check_eq("rst_clear", {31'd0, counter_clear_o}, 0);
    check_eq("rst_event", {31'd0, event_o}, 0);
    check_eq("rst_irq", {31'd0, irq_o}, 0);
`ifdef TIMER_CMP_OVERRUN_EN
    check_eq("rst_ovr", overrun_o, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Continuous, cmp 4: period of 5 cycles
    arm(32'd4, 1'b1);
    exp_q.push_back(s + 6); exp_q.push_back(s + 11); exp_q.push_back(s + 16);
    check_eq("s1_cnt_first", cnt, 0);
    check_eq("s1_state", state_o, 1);
    check_eq("s1_en", {31'd0, counter_enable_o}, 1);
    goto(s + 5);
    check_eq("s1_cnt_top", cnt, 4);
    check_eq("s1_clear_match", {31'd0, counter_clear_o}, 1);
    goto(s + 6);
    check_eq("s1_cnt_wrap", cnt, 0);
    goto(s + 18);
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("s1_stop_state", state_o, 0);
    check_eq("s1_stop_en", {31'd0, counter_enable_o}, 0);
    check_eq("s1_irq", {31'd0, irq_o}, 1);
    goto(s + 24);
    drain("s1_drain");
    ack_irq();

    // One-shot, cmp 3
    arm(32'd3, 1'b0);
    exp_q.push_back(s + 5);
    goto(s + 4);
    check_eq("s2_cnt_match", cnt, 3);
    goto(s + 8);
    check_eq("s2_state_done", state_o, 2);
    check_eq("s2_en_off", {31'd0, counter_enable_o}, 0);
    check_eq("s2_cnt_frozen", cnt, 4);
    goto(s + 12);
    drain("s2_drain");
    ack_irq();

    // Compare write on the match cycle applies to the next period
    arm(32'd2, 1'b1);
    exp_q.push_back(s + 4); exp_q.push_back(s + 12);
    goto(s + 3);
    check_eq("s3_cnt_match", cnt, 2);
    cmp_we = 1'b1; cmp_value = 32'd7; tick(); cmp_we = 1'b0;
    goto(s + 11);
    check_eq("s3_cnt_new", cnt, 7);
    goto(s + 13);
    stop = 1'b1; tick(); stop = 1'b0;
    goto(s + 18);
    drain("s3_drain");
    ack_irq();

    // Back-to-back events with irq pending, period 2
    arm(32'd1, 1'b1);
    for (int k = 0; k < 260; k++) exp_q.push_back(s + 3 + 2 * k);
    for (int k = 0; k < 260; k++) begin
      goto(s + 3 + 2 * k);
      if (k == 0) check_eq("s4_irq_set", {31'd0, irq_o}, 1);
`ifdef TIMER_CMP_OVERRUN_EN
      if (k < 3 || k == 254 || k == 255 || k == 259)
        check_eq("s4_ovr", overrun_o, (k > 255) ? 255 : k);
`endif
    end
    e_last = cyc;
    stop = 1'b1; tick(); stop = 1'b0;
    goto(e_last + 4);
    drain("s4_drain");
    ack_irq();
`ifdef TIMER_CMP_OVERRUN_EN
    check_eq("s4_ovr_ack", overrun_o, 0);
`endif

    // Start and stop together while armed: stop wins
    arm(32'd5, 1'b1);
    goto(s + 3);
    start = 1'b1; stop = 1'b1;
    #1 check_eq("s5_no_clear", {31'd0, counter_clear_o}, 0);
    tick();
    start = 1'b0; stop = 1'b0;
    check_eq("s5_state", state_o, 0);
    check_eq("s5_en", {31'd0, counter_enable_o}, 0);
    goto(s + 15);
    drain("s5_drain");

    // Asynchronous reset mid-period
    arm(32'd5, 1'b1);
    goto(s + 3);
    check_eq("s6_cnt", cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("s6_state", state_o, 0);
    check_eq("s6_en", {31'd0, counter_enable_o}, 0);
    check_eq("s6_clear", {31'd0, counter_clear_o}, 0);
    check_eq("s6_event", {31'd0, event_o}, 0);
    check_eq("s6_irq", {31'd0, irq_o}, 0);
    tick();
    rst_n = 1'b1;
    goto(s + 20);
    check_eq("s6_irq_after", {31'd0, irq_o}, 0);
    drain("s6_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
